// File: rtl/cobra_prog_loader.sv
// cobra_prog_loader: receives a framed program byte stream (sync, 16-bit word
// count, little-endian instruction words, XOR checksum), writes each completed
// word into instruction memory and holds the CYBERcobra core in reset until a
// frame has loaded with a matching checksum.
module cobra_prog_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [23:0] asm_q, asm_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        ready_q, ready_d;
    logic        core_rst_q, core_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic [15:0] count_full;

    // A byte transfers only when the loader advertises ready; ready is
    // withheld exactly in the cycle the write strobe is up.
    assign accept     = rx_valid_i & ready_q;
    assign count_full = {rx_data_i, cnt_q[7:0]};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        xor_d       = xor_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (accept) begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    // Anything other than the sync byte is dropped silently.
                    if (rx_data_i == SYNC_BYTE) begin
                        state_d    = CNT_LO;
                        word_idx_d = 16'd0;
                        byte_idx_d = 2'd0;
                        xor_d      = 8'd0;
                    end
                end
                CNT_LO: begin
                    cnt_d[7:0] = rx_data_i;
                    state_d    = CNT_HI;
                end
                CNT_HI: begin
                    cnt_d[15:8] = rx_data_i;
                    if (count_full == 16'd0) begin
                        state_d = CHECK;
                    end else if ({16'd0, count_full} > 32'(MEM_WORDS)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    // Any byte value here, including 0xA5, is payload.
                    xor_d      = xor_q ^ rx_data_i;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    asm_d[7:0]   = rx_data_i;
                        2'd1:    asm_d[15:8]  = rx_data_i;
                        2'd2:    asm_d[23:16] = rx_data_i;
                        default: asm_d        = asm_q;
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {14'd0, word_idx_q, 2'b00};
                        mem_wdata_d = {rx_data_i, asm_q};
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == (cnt_q - 16'd1)) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    state_d = (rx_data_i == xor_q) ? DONE : ERROR;
                end
                default: state_d = IDLE;
            endcase
        end

        ready_d    = ~mem_we_d;
        core_rst_d = (state_d != DONE);
        busy_d     = (state_d == CNT_LO) || (state_d == CNT_HI) ||
                     (state_d == DATA)   || (state_d == CHECK);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERROR);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            xor_q       <= 8'd0;
            asm_q       <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            ready_q     <= 1'b0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            xor_q       <= xor_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ready_q     <= ready_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready_o  = ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign core_rst_o  = core_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_cobra_prog_loader.sv
// Testbench for cobra_prog_loader: directed frames, expected memory writes
// queued by the stimulus and checked by an independent write monitor.
module tb_cobra_prog_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    cobra_prog_loader #(.MEM_WORDS(256)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .core_rst_o (core_rst),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with nothing expected",
                         mem_addr, mem_wdata);
            end else begin
                logic [31:0] ea, ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    failures++;
                    $display("FAIL write: got 0x%08h/0x%08h expected 0x%08h/0x%08h",
                             mem_addr, mem_wdata, ea, ed);
                end
                if (rx_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL ready_during_write: got %0b expected 0", rx_ready);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [7:0] b);
        int waited;
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: rx_ready %0b expected 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_addr_q.size()), 32'd0);
    endtask

    // Frame A: words 0x00000013, 0x00100093; checksum 13^93^10 = 0x90.
    task automatic frame_a(input logic [7:0] csum, input int gap);
        logic [7:0] body[8];
        body = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        expect_write(32'h0, 32'h0000_0013);
        expect_write(32'h4, 32'h0010_0093);
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        for (int i = 0; i < 8; i++) begin
            send(body[i]);
            if (gap > 0) idle(gap);
        end
        send(csum);
        idle(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(rx_ready), 32'd1);

        // Junk bytes in IDLE are discarded.
        send(8'hFF);
        check("junk_ff_busy", 32'(busy), 32'd0);
        send(8'h11);
        check("junk_11_busy", 32'(busy), 32'd0);
        idle(1);

        // Good frame.
        frame_a(8'h90, 0);
        check_drained("a_writes");
        check("a_done", {29'd0, busy, done, err}, 32'b010);
        check("a_core_rst", 32'(core_rst), 32'd0);
        check("a_addr_hold", mem_addr, 32'h4);
        check("a_wdata_hold", mem_wdata, 32'h0010_0093);

        // Sync while DONE puts the core back into reset at once.
        expect_write(32'h0, 32'h0000_0013);
        expect_write(32'h4, 32'h0010_0093);
        send(8'hA5);
        check("restart_core_rst", 32'(core_rst), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        send(8'h02);
        send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'h00);
        idle(1);
        check_drained("bad_csum_writes");
        check("bad_csum_err", {29'd0, busy, done, err}, 32'b001);
        check("bad_csum_core_rst", 32'(core_rst), 32'd1);

        // Empty frame.
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        check("empty_done", {29'd0, busy, done, err}, 32'b010);
        check("empty_core_rst", 32'(core_rst), 32'd0);

        // Count 257 exceeds capacity.
        send(8'hA5); send(8'h01); send(8'h01);
        idle(2);
        check("oversize_err", {29'd0, busy, done, err}, 32'b001);
        check_drained("oversize_writes");

        // Gaps inside the data phase.
        frame_a(8'h90, 5);
        check_drained("gap_writes");
        check("gap_done", {29'd0, busy, done, err}, 32'b010);

        // Reset after 6 data bytes: one word already written.
        expect_write(32'h0, 32'h0000_0013);
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00);
        rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_core_rst", 32'(core_rst), 32'd1);
        check("mid_rst_flags", {29'd0, busy, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_drained("mid_rst_writes");
        frame_a(8'h90, 0);
        check_drained("post_rst_writes");
        check("post_rst_done", {29'd0, busy, done, err}, 32'b010);
        check("post_rst_core_rst", 32'(core_rst), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
